// File: rtl/time_set_buttons_if.sv
// Button-side bus of the time-set front end: raw buttons and set-mode in,
// clean increment/decrement pulses and debounced levels out.
interface time_set_buttons_if;
  logic [3:0] btn_raw;    // [0]=min_inc [1]=min_dec [2]=hour_inc [3]=hour_dec
  logic       set_mode;
  logic       min_inc;
  logic       min_dec;
  logic       hour_inc;
  logic       hour_dec;
  logic [3:0] btn_level;

  // Stimulus / upstream side
  modport master (
    output btn_raw,
    output set_mode,
    input  min_inc,
    input  min_dec,
    input  hour_inc,
    input  hour_dec,
    input  btn_level
  );

  // Conditioner side
  modport slave (
    input  btn_raw,
    input  set_mode,
    output min_inc,
    output min_dec,
    output hour_inc,
    output hour_dec,
    output btn_level
  );
endinterface

// File: rtl/time_set_buttons.sv
// Time-set pushbutton conditioner: 2-flop synchroniser, per-button debounce,
// press pulse (optionally with hold-to-repeat), pair conflict suppression
// and set_mode gating. All outputs are registered.
// Optional feature macro: TIME_SET_AUTO_REPEAT_EN. When defined, a held
// button repeats after REPEAT_DELAY_CYC and then every REPEAT_PERIOD_CYC;
// when undefined, each accepted press yields exactly one pulse.
module time_set_buttons #(
  parameter int DEBOUNCE_CYC      = 655,
  parameter int REPEAT_DELAY_CYC  = 16384,
  parameter int REPEAT_PERIOD_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset,
  time_set_buttons_if.slave bus
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ?
                           REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
`endif

  // Zero-length intervals would make the terminal counts meaningless.
  if (DEBOUNCE_CYC < 1 || REPEAT_DELAY_CYC < 1 || REPEAT_PERIOD_CYC < 1) begin : g_param_check
    $error("time_set_buttons: cycle-count parameters must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic [3:0] level_vec;
  logic [3:0] level_dly_reg;
  logic [3:0] level_rise;
  logic [3:0] pulse_vec;
  logic       set_mode;

  assign set_mode = bus.set_mode;

  // Two-flop synchroniser for the asynchronous raw buttons
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= bus.btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Previous debounced level, for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      level_dly_reg <= '0;
    end else begin
      level_dly_reg <= level_vec;
    end
  end

  // A press is only a fresh 0->1 of the debounced level; a button already
  // held when set_mode rises therefore never produces a pulse.
  assign level_rise = level_vec & ~level_dly_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic            level_reg;
      logic [DB_W-1:0] db_cnt_reg;
      state_t          state_reg;
      state_t          state_next;
      logic            fire;
      logic            conflict;
      logic            pulse_reg;
`ifdef TIME_SET_AUTO_REPEAT_EN
      logic [RPT_W-1:0] rpt_cnt_reg;
      logic [RPT_W-1:0] rpt_cnt_next;
      logic             delay_done;
      logic             period_done;

      assign delay_done  = (rpt_cnt_reg == RPT_W'(REPEAT_DELAY_CYC - 1));
      assign period_done = (rpt_cnt_reg == RPT_W'(REPEAT_PERIOD_CYC - 1));
`endif

      // Debounce: accept a new level after DEBOUNCE_CYC consecutive differing samples
      always_ff @(posedge clk) begin
        if (reset) begin
          level_reg  <= 1'b0;
          db_cnt_reg <= '0;
        end else if (sync2_reg[gi] == level_reg) begin
          db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_W'(DEBOUNCE_CYC - 1)) begin
          level_reg  <= sync2_reg[gi];
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + DB_W'(1);
        end
      end

      assign level_vec[gi] = level_reg;

      // FSM state register (and repeat counter when auto-repeat is built in)
      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg   <= IDLE;
`ifdef TIME_SET_AUTO_REPEAT_EN
          rpt_cnt_reg <= '0;
`endif
        end else begin
          state_reg   <= state_next;
`ifdef TIME_SET_AUTO_REPEAT_EN
          rpt_cnt_reg <= rpt_cnt_next;
`endif
        end
      end

`ifdef TIME_SET_AUTO_REPEAT_EN
      // Next state: release always wins over a same-cycle terminal count
      always_comb begin
        state_next   = state_reg;
        rpt_cnt_next = rpt_cnt_reg;
        if (!set_mode) begin
          state_next   = IDLE;
          rpt_cnt_next = '0;
        end else begin
          case (state_reg)
            IDLE: begin
              if (level_rise[gi]) begin
                state_next   = HOLD;
                rpt_cnt_next = '0;
              end
            end
            HOLD: begin
              if (!level_reg) begin
                state_next   = IDLE;
                rpt_cnt_next = '0;
              end else if (delay_done) begin
                state_next   = REPEAT;
                rpt_cnt_next = '0;
              end else begin
                rpt_cnt_next = rpt_cnt_reg + RPT_W'(1);
              end
            end
            REPEAT: begin
              if (!level_reg) begin
                state_next   = IDLE;
                rpt_cnt_next = '0;
              end else if (period_done) begin
                rpt_cnt_next = '0;
              end else begin
                rpt_cnt_next = rpt_cnt_reg + RPT_W'(1);
              end
            end
            default: begin
              state_next   = IDLE;
              rpt_cnt_next = '0;
            end
          endcase
        end
      end
`else
      // Next state: single pulse per press, HOLD lasts until release
      always_comb begin
        state_next = state_reg;
        if (!set_mode) begin
          state_next = IDLE;
        end else begin
          case (state_reg)
            IDLE:    if (level_rise[gi]) state_next = HOLD;
            HOLD:    if (!level_reg) state_next = IDLE;
            default: state_next = IDLE;
          endcase
        end
      end
`endif

      // Output decode: which transitions emit a pulse
      always_comb begin
        fire = 1'b0;
        if (set_mode) begin
          case (state_reg)
            IDLE:    fire = level_rise[gi];
`ifdef TIME_SET_AUTO_REPEAT_EN
            HOLD:    fire = level_reg & delay_done;
            REPEAT:  fire = level_reg & period_done;
`endif
            default: fire = 1'b0;
          endcase
        end
      end

      // Both members of a pair held means the user intent is ambiguous
      assign conflict = level_vec[gi] & level_vec[gi ^ 1];

      // Registered one-cycle output pulse
      always_ff @(posedge clk) begin
        if (reset) begin
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= fire & ~conflict;
        end
      end

      assign pulse_vec[gi] = pulse_reg;
    end
  endgenerate

  assign bus.min_inc   = pulse_vec[0];
  assign bus.min_dec   = pulse_vec[1];
  assign bus.hour_inc  = pulse_vec[2];
  assign bus.hour_dec  = pulse_vec[3];
  assign bus.btn_level = level_vec;

endmodule

// File: tb/tb_time_set_buttons.sv
// Self-checking bench for time_set_buttons with short timing parameters.
// A behavioural model (time-since-press arithmetic, sample-window debounce)
// is compared against the DUT on every cycle; literal cycle expectations
// pin the model for the directed scenarios.
module tb_time_set_buttons;
  localparam int DB  = 4;
  localparam int DLY = 20;
  localparam int PER = 8;
`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam bit AUTO_REPEAT = 1'b1;
`else
  localparam bit AUTO_REPEAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  time_set_buttons_if bus ();

  time_set_buttons #(
    .DEBOUNCE_CYC      (DB),
    .REPEAT_DELAY_CYC  (DLY),
    .REPEAT_PERIOD_CYC (PER)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;   // number of rising edges so far

  // Behavioural model state
  logic [3:0] m_level = '0;
  logic [3:0] m_prev  = '0;
  logic [3:0] m_pulse = '0;
  logic [3:0] raw_d1  = '0;
  logic [3:0] raw_d2  = '0;
  logic [3:0] s_hist [$];
  int         hold_t [4];   // cycles since accepted press, -1 when not holding

  // Observation logs
  int log0 [$];
  int log1 [$];
  int log2 [$];
  int log3 [$];
  int lvl0_rise = -1;
  bit seen_level2 = 1'b0;

  // Pulse due t cycles after the press pulse (press itself is t=0)
  function automatic bit repeat_due(input int t);
    return AUTO_REPEAT && ((t == DLY) || (t > DLY && ((t - DLY) % PER) == 0));
  endfunction

  task automatic model_step();
    logic [3:0] np;
    logic [3:0] s;
    bit         all_diff;
    np = '0;
    if (reset) begin
      m_level = '0;
      m_prev  = '0;
      raw_d1  = '0;
      raw_d2  = '0;
      s_hist.delete();
      for (int b = 0; b < 4; b++) hold_t[b] = -1;
      m_pulse = '0;
      return;
    end
    for (int b = 0; b < 4; b++) begin
      if (!bus.set_mode) begin
        hold_t[b] = -1;
      end else if (hold_t[b] < 0) begin
        if (m_level[b] && !m_prev[b]) begin
          hold_t[b] = 0;
          np[b] = 1'b1;
        end
      end else if (!m_level[b]) begin
        hold_t[b] = -1;
      end else begin
        hold_t[b] = hold_t[b] + 1;
        np[b] = repeat_due(hold_t[b]);
      end
    end
    if (m_level[0] && m_level[1]) np[1:0] = 2'b00;
    if (m_level[2] && m_level[3]) np[3:2] = 2'b00;
    m_prev = m_level;
    // Synchronised sample window: level follows once DB samples all disagree
    s = raw_d2;
    s_hist.push_back(s);
    if (s_hist.size() > DB) void'(s_hist.pop_front());
    if (s_hist.size() == DB) begin
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DB; k++) begin
          if (s_hist[k][b] == m_level[b]) all_diff = 1'b0;
        end
        if (all_diff) m_level[b] = s[b];
      end
    end
    raw_d2  = raw_d1;
    raw_d1  = bus.btn_raw;
    m_pulse = np;
  endtask

  // Model advances on every rising edge
  initial begin
    for (int b = 0; b < 4; b++) hold_t[b] = -1;
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  function automatic logic [7:0] dut_out();
    return {bus.hour_dec, bus.hour_inc, bus.min_dec, bus.min_inc, bus.btn_level};
  endfunction

  // Per-cycle compare against the model, plus pulse logging
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        total++;
        if (dut_out() !== {m_pulse, m_level}) begin
          bad++;
          $display("FAIL cycle %0d outputs: pulses=%b level=%b, required pulses=%b level=%b",
                   cyc, dut_out() >> 4, bus.btn_level, m_pulse, m_level);
        end
        if (bus.min_inc === 1'b1)  log0.push_back(cyc);
        if (bus.min_dec === 1'b1)  log1.push_back(cyc);
        if (bus.hour_inc === 1'b1) log2.push_back(cyc);
        if (bus.hour_dec === 1'b1) log3.push_back(cyc);
        if (bus.btn_level[0] === 1'b1 && lvl0_rise < 0) lvl0_rise = cyc;
        if (bus.btn_level[2] === 1'b1) seen_level2 = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    log0.delete();
    log1.delete();
    log2.delete();
    log3.delete();
    lvl0_rise   = -1;
    seen_level2 = 1'b0;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  task automatic check_list(input string name, input int got[$], input int want[$]);
    bit    ok;
    string gs;
    string ws;
    ok = (got.size() == want.size());
    gs = "";
    ws = "";
    for (int i = 0; i < got.size(); i++) begin
      gs = {gs, $sformatf(" %0d", got[i])};
      if (ok && got[i] != want[i]) ok = 1'b0;
    end
    for (int i = 0; i < want.size(); i++) ws = {ws, $sformatf(" %0d", want[i])};
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: pulse cycles [%s ] required [%s ]", name, gs, ws);
    end else begin
      $display("ok   %s: pulse cycles [%s ]", name, gs);
    end
  endtask

  int pe;
  int rs;
  int want [$];
  int rep_off [5] = '{26, 34, 42, 50, 58};

  initial begin
    reset        = 1'b1;
    bus.btn_raw  = '0;
    bus.set_mode = 1'b1;
    tick(3);
    check_val("reset_outputs", {24'd0, dut_out()}, 32'd0);
    reset = 1'b0;
    tick(2);

    // Clean press on min_inc: level at +5 edges, single pulse at +6
    clear_logs();
    pe = cyc + 1;
    bus.btn_raw[0] = 1'b1;
    tick(15);
    bus.btn_raw[0] = 1'b0;
    tick(12);
    want.delete();
    want.push_back(pe + 6);
    check_list("clean_min_inc", log0, want);
    check_val("clean_level_rise", lvl0_rise, pe + 5);
    check_val("clean_other_pulses", log1.size() + log2.size() + log3.size(), 0);

    // Bounce on hour_inc: 2-cycle runs never qualify
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      bus.btn_raw[2] = (i % 2 == 0);
      tick(2);
    end
    bus.btn_raw[2] = 1'b0;
    tick(12);
    want.delete();
    check_list("bounce_hour_inc", log2, want);
    check_val("bounce_level2_seen", seen_level2, 0);

    // Hold on min_dec for 60 cycles; release coincides with a terminal count
    clear_logs();
    pe = cyc + 1;
    bus.btn_raw[1] = 1'b1;
    tick(60);
    bus.btn_raw[1] = 1'b0;
    tick(20);
    want.delete();
    want.push_back(pe + 6);
    if (AUTO_REPEAT) begin
      for (int i = 0; i < 5; i++) want.push_back(pe + rep_off[i]);
    end
    check_list("hold_min_dec", log1, want);

    // Conflicting hour pair, independent min_inc, then reset mid-hold
    clear_logs();
    bus.btn_raw[3:2] = 2'b11;
    tick(8);
    pe = cyc + 1;
    bus.btn_raw[0] = 1'b1;
    tick(10);
    rs = cyc + 1;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_val("reset_mid_hold_outputs", {24'd0, dut_out()}, 32'd0);
    tick(12);
    bus.btn_raw = '0;
    tick(12);
    want.delete();
    want.push_back(pe + 6);
    want.push_back(rs + 7);
    check_list("conflict_min_inc", log0, want);
    want.delete();
    check_list("conflict_hour_inc", log2, want);
    check_list("conflict_hour_dec", log3, want);

    // set_mode gating: press while disabled, enable while held, re-press
    clear_logs();
    bus.set_mode   = 1'b0;
    bus.btn_raw[0] = 1'b1;
    tick(12);
    check_val("gated_level_valid", bus.btn_level[0], 1);
    bus.set_mode = 1'b1;
    tick(10);
    want.delete();
    check_list("gated_no_pulse", log0, want);
    bus.btn_raw[0] = 1'b0;
    tick(10);
    pe = cyc + 1;
    bus.btn_raw[0] = 1'b1;
    tick(10);
    bus.btn_raw[0] = 1'b0;
    tick(12);
    want.push_back(pe + 6);
    check_list("gated_repress", log0, want);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
